// File: rtl/count_checker.sv
// Read-side checker for a loadable up/down counter: runs a reference model
// beside the counter and reports mismatches as pulse, sticky and counts.
module count_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned CHK_CNT_W = 16,
  parameter bit          RESYNC    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 load,
  input  logic                 up_dn,
  input  logic [WIDTH-1:0]     count,
  input  logic                 chk_en,
  input  logic                 clr,
  output logic [WIDTH-1:0]     exp_count,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CHK_CNT_W-1:0] chk_cnt,
  output logic [WIDTH-1:0]     first_err_exp,
  output logic [WIDTH-1:0]     first_err_act,
  output logic                 halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             mismatch_c;
  logic [WIDTH-1:0] base_c;
  logic [WIDTH-1:0] exp_nxt_c;

  // Compare and model next value; base follows the real count on resync or HALT exit
  always_comb begin
    mismatch_c = (state == CHECK) && (count != exp_count);
    base_c     = exp_count;
    if ((mismatch_c && RESYNC) || (clr && (state == HALT))) begin
      base_c = count;
    end
    if (load) begin
      exp_nxt_c = d_in;
    end else if (up_dn) begin
      exp_nxt_c = base_c + WIDTH'(1);
    end else begin
      exp_nxt_c = base_c - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (chk_en) state_nxt = CHECK;
      end
      CHECK: begin
        if (mismatch_c && !RESYNC) begin
          state_nxt = HALT;
        end else if (!chk_en) begin
          state_nxt = IDLE;
        end
      end
      HALT: begin
        if (clr) state_nxt = chk_en ? CHECK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Error reporting; clr beats a same-cycle mismatch for everything but the pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_count     <= '0;
      err           <= 1'b0;
      err_sticky    <= 1'b0;
      err_cnt       <= '0;
      chk_cnt       <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      halted        <= 1'b0;
    end else begin
      exp_count <= exp_nxt_c;
      err       <= mismatch_c;
      halted    <= (state_nxt == HALT);
      if (clr) begin
        err_sticky    <= 1'b0;
        err_cnt       <= '0;
        chk_cnt       <= '0;
        first_err_exp <= '0;
        first_err_act <= '0;
      end else begin
        if (mismatch_c) begin
          err_sticky <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
          if (!err_sticky) begin
            first_err_exp <= exp_count;
            first_err_act <= count;
          end
        end
        if ((state == CHECK) && (chk_cnt != '1)) begin
          chk_cnt <= chk_cnt + CHK_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Hardware read-side checker for the 4-bit loadable up/down counter. It observes the counter's control inputs (d_in, load, up_dn) and its count output on the same clock.
- It runs an internal reference model, compares the predicted value against the actual count every cycle, and reports mismatches through pulse, sticky and counter outputs.
- It sits beside the counter in the bench or in emulation as a self-checking responder to the stimulus driver.

Parameters:
- WIDTH, 4, width of d_in, count and all expected/captured values.
- ERR_CNT_W, 8, width of the saturating mismatch counter.
- CHK_CNT_W, 16, width of the saturating compare counter.
- RESYNC, 1, on mismatch: 1 = adopt the actual count and keep checking; 0 = halt comparing until clr.

Ports:
- clk  input  1  single clock; all sampling on posedge.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk).
- d_in  input  WIDTH  counter load data as driven to the counter.
- load  input  1  counter load strobe.
- up_dn  input  1  counter direction; 1 = up, 0 = down.
- count  input  WIDTH  actual counter output.
- chk_en  input  1  compare enable.
- clr  input  1  synchronous clear of error status; exits HALT.
- exp_count  output  WIDTH  model's predicted count for the current cycle.
- err  output  1  one-cycle mismatch pulse.
- err_sticky  output  1  set on any mismatch; held until clr or reset.
- err_cnt  output  ERR_CNT_W  saturating mismatch count.
- chk_cnt  output  CHK_CNT_W  saturating count of compares performed.
- first_err_exp  output  WIDTH  expected value at the first mismatch.
- first_err_act  output  WIDTH  actual value at the first mismatch.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (rst=0 at posedge): all outputs 0, state IDLE. exp_count=0, matching the counter's reset value of 0.
- Model update each posedge, out of reset, in every state:
  - base = count if (mismatch this cycle and RESYNC=1) or (clr in HALT), otherwise base = exp_count.
  - if load, exp_count <= d_in.
  - else if up_dn, exp_count <= base+1.
  - else exp_count <= base-1.
  - Arithmetic is modulo 2^WIDTH: F+1=0, 0-1=F.
- Compare: mismatch = (state==CHECK) && (count != exp_count). Both operands are registered values from the previous edge, so there is zero-cycle alignment.
- Mismatch response, registered at the same posedge, visible one cycle after the bad count is observed:
  - err=1 for exactly one cycle.
  - err_sticky=1.
  - err_cnt+1, saturating at all-ones.
  - first_err_exp and first_err_act capture the values only when err_sticky was 0.
- chk_cnt increments on every CHECK cycle, saturating at all-ones.
- State machine:
  - IDLE -> CHECK when chk_en=1.
  - CHECK -> IDLE when chk_en=0.
  - CHECK -> HALT on mismatch when RESYNC=0.
  - HALT -> CHECK on clr=1 (if chk_en=1), else HALT -> IDLE on clr=1.
  - HALT ignores chk_en; no compares occur in HALT.
- clr: zeroes err_sticky, err_cnt, chk_cnt, first_err_exp and first_err_act. If a mismatch occurs in the same cycle, clr wins for the counters and sticky, but err still pulses.
- The model keeps tracking in IDLE, so re-enabling needs no resync.
- Simultaneous load and mismatch: the load value takes precedence for exp_count, and the mismatch is still reported.
- Reset mid-operation: everything returns to reset values on that edge, regardless of state, clr or chk_en.

Test Plan:
- Reset, then chk_en=1, up_dn=1, counter counting 1,2,3,4,5 -> err never asserts; chk_cnt=5; exp_count tracks count.
- load=1 with d_in=4'hA, then down for 3 cycles -> exp_count A,9,8,7; no err.
- load d_in=4'hE, up for 3 cycles -> F,0,1 (wrap); down from 0 -> F; no err.
- Force count=3 while exp_count=7 (RESYNC=1) -> err high for one cycle; err_cnt=1; first_err_exp=7; first_err_act=3; next cycle expects 4 (up) and matches with no further err.
- RESYNC=0, same injection -> halted=1, chk_cnt frozen, a second injection gives no err. Then clr=1 -> halted=0, err_cnt=0, err_sticky=0, and the model adopts count.
- ERR_CNT_W=2, inject 5 mismatches -> err_cnt saturates at 3. Then drive rst=0 mid-run -> all outputs 0 and state IDLE on that edge.
